dm_responder: RTL and testbench

//   Data-memory responder for the multi-cycle MIPS core. It is the memory side
//   of the controller's load/store traffic: it accepts one lw/sw/lb/sb request,

---
 rtl/dm_responder.sv | 177 +++++++++++++++++
 tb/tb_dm_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
`timescale 1ns/1ps
// Data-memory responder for the multi-cycle MIPS core: serves one lw/sw/lb/sb
// at a time after WAIT_CYCLES wait states and answers with a one-cycle ready pulse.
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic        i_byte,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_MERGE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;

  logic              r_we;
  logic              r_byte;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge_word;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_word;
  logic [1:0]        w_lane;
  logic              w_misaligned;
  logic              w_accept;
  logic [31:0]       w_mem_rd;
  logic              w_mem_we;
  logic [31:0]       w_mem_wdata;
  logic              w_resp_load;
  logic [31:0]       w_resp_rdata;
  logic              w_resp_err;
  logic              w_unused_addr;

  // Little-endian lane select with sign extension to 32 bits.
  function automatic logic [31:0] f_lane_sext(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    b = word[{lane, 3'b000} +: 8];
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] f_lane_merge(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [7:0] b);
    logic [31:0] merged;
    merged = word;
    merged[{lane, 3'b000} +: 8] = b;
    return merged;
  endfunction

  assign w_word        = r_addr[ADDR_W+1:2];
  assign w_lane        = r_addr[1:0];
  assign w_misaligned  = !r_byte && (w_lane != 2'b00);
  assign w_accept      = (r_state == S_IDLE) && i_req;
  assign w_mem_rd      = r_mem[w_word];
  assign w_unused_addr = ^i_addr[31:ADDR_W+2];

  assign o_ready = (r_state == S_RESP);
  assign o_busy  = (r_state != S_IDLE);
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_we       = 1'b0;
    w_mem_wdata    = r_wdata;
    w_resp_load    = 1'b0;
    w_resp_rdata   = '0;
    w_resp_err     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        // A misaligned word access still spends its ACCESS cycle but never writes.
        if (w_misaligned) begin
          w_resp_load = 1'b1;
          w_resp_err  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (!r_we) begin
          w_resp_load  = 1'b1;
          w_resp_rdata = r_byte ? f_lane_sext(w_mem_rd, w_lane) : w_mem_rd;
          w_state_nxt  = S_RESP;
        end else if (!r_byte) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = r_wdata;
          w_resp_load = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_MERGE;
        end
      end
      S_MERGE: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = f_lane_merge(r_merge_word, w_lane, r_wdata[7:0]);
        w_resp_load = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_resp_load) begin
        r_rdata <= w_resp_rdata;
        r_err   <= w_resp_err;
      end
    end
  end

  // Request fields and the sb read word carry no reset; they are only consumed under FSM control.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= i_we;
      r_byte  <= i_byte;
      r_addr  <= i_addr[ADDR_W+1:0];
      r_wdata <= i_wdata;
    end
    if (r_state == S_ACCESS) begin
      r_merge_word <= w_mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_word] <= w_mem_wdata;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
// Bench for dm_responder: a transaction-level timing model predicts ready, busy,
// rdata and err every cycle; directed cases pin the model with literal values.
module tb_dm_responder;

  localparam int WA = 2;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        t_we = 1'b0;
  logic        t_byte = 1'b0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_busy, a_err;
  logic        b_ready, b_busy, b_err;

  int n_cmp = 0;
  int n_fail = 0;

  dm_responder #(.ADDR_W(AW), .WAIT_CYCLES(WA)) u_dut_a (
    .clk(clk), .reset(reset), .i_req(req_a), .i_we(t_we), .i_byte(t_byte),
    .i_addr(t_addr), .i_wdata(t_wdata), .o_rdata(a_rdata), .o_ready(a_ready),
    .o_busy(a_busy), .o_err(a_err)
  );

  dm_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .i_req(req_b), .i_we(t_we), .i_byte(t_byte),
    .i_addr(t_addr), .i_wdata(t_wdata), .o_rdata(b_rdata), .o_ready(b_ready),
    .o_busy(b_busy), .o_err(b_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for instance A: each accepted request completes a fixed
  // number of edges later; memory is a plain word array.
  logic [31:0] m_mem [int];
  bit          m_init = 1'b0;
  bit          m_pending = 1'b0;
  int          m_edge = 0;
  int          m_resp_edge = 0;
  logic        m_we, m_byte;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_init    = 1'b1;
      m_pending = 1'b0;
      m_rdata   = '0;
      m_err     = 1'b0;
    end else begin
      m_edge++;
      if (m_pending) begin
        if (m_edge == m_resp_edge) begin
          int          idx;
          int          sh;
          logic [31:0] b;
          idx = int'(m_addr[AW+1:2]);
          sh  = 8 * int'(m_addr[1:0]);
          if (!m_byte && m_addr[1:0] != 2'b00) begin
            m_rdata = '0;
            m_err   = 1'b1;
          end else begin
            m_err = 1'b0;
            if (m_we) begin
              m_rdata = '0;
              if (m_byte)
                m_mem[idx] = (m_mem[idx] & ~(32'hFF << sh)) | ({24'h0, m_wdata[7:0]} << sh);
              else
                m_mem[idx] = m_wdata;
            end else if (m_byte) begin
              b = (m_mem[idx] >> sh) & 32'hFF;
              m_rdata = (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            end else begin
              m_rdata = m_mem[idx];
            end
          end
        end
        if (m_edge == m_resp_edge + 1) m_pending = 1'b0;
      end else if (req_a === 1'b1) begin
        m_pending   = 1'b1;
        m_we        = t_we;
        m_byte      = t_byte;
        m_addr      = t_addr;
        m_wdata     = t_wdata;
        m_resp_edge = m_edge + 1 + WA + ((t_we && t_byte) ? 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_ready", {31'b0, a_ready}, {31'b0, (m_pending && (m_edge == m_resp_edge))});
      chk("cyc_busy",  {31'b0, a_busy},  {31'b0, m_pending});
      chk("cyc_rdata", a_rdata, m_rdata);
      chk("cyc_err",   {31'b0, a_err},   {31'b0, m_err});
    end
  end

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while ((sel ? b_busy : a_busy) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", {31'b0, (sel ? b_busy : a_busy)}, 32'd0);
  endtask

  task automatic do_op(input bit sel, input bit we, input bit byt, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    logic rdy;
    wait_idle(sel);
    t_we = we; t_byte = byt; t_addr = addr; t_wdata = wd;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      rdy = sel ? b_ready : a_ready;
    end while (!rdy && lat < 50);
    chk("op_done", {31'b0, rdy}, 32'd1);
    rd = sel ? b_rdata : a_rdata;
    er = sel ? b_err : a_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses, idles;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_a_busy",  {31'b0, a_busy},  32'd0);
    chk("rst_a_err",   {31'b0, a_err},   32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_busy",  {31'b0, b_busy},  32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);

    for (int i = 0; i < 24; i++)
      do_op(1'b0, 1'b1, 1'b0, 32'(i) << 2, 32'hA5A5_0000 | 32'(i), rd, er, lat);

    // T1
    do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    chk("T1_sw_lat", lat, 32'd3);
    chk("T1_sw_rdata", rd, 32'd0);
    do_op(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("T1_lw_lat", lat, 32'd3);
    chk("T1_lw_rdata", rd, 32'hDEAD_BEEF);
    chk("T1_lw_err", {31'b0, er}, 32'd0);
    chk("T1_model", m_rdata, 32'hDEAD_BEEF);

    // T2
    do_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h1122_3344, rd, er, lat);
    do_op(1'b0, 1'b1, 1'b1, 32'h22, 32'h0000_00AB, rd, er, lat);
    chk("T2_sb_lat", lat, 32'd4);
    do_op(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("T2_lw_rdata", rd, 32'h11AB_3344);
    chk("T2_model", m_rdata, 32'h11AB_3344);

    // T3
    do_op(1'b0, 1'b1, 1'b0, 32'h30, 32'h0080_FF7F, rd, er, lat);
    do_op(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, rd, er, lat);
    chk("T3_lb0", rd, 32'h0000_007F);
    do_op(1'b0, 1'b0, 1'b1, 32'h31, 32'h0, rd, er, lat);
    chk("T3_lb1", rd, 32'hFFFF_FFFF);
    chk("T3_lb1_lat", lat, 32'd3);
    do_op(1'b0, 1'b0, 1'b1, 32'h32, 32'h0, rd, er, lat);
    chk("T3_lb2", rd, 32'hFFFF_FF80);
    chk("T3_model", m_rdata, 32'hFFFF_FF80);
    do_op(1'b0, 1'b0, 1'b1, 32'h33, 32'h0, rd, er, lat);
    chk("T3_lb3", rd, 32'h0000_0000);

    // T4
    do_op(1'b0, 1'b1, 1'b0, 32'h40, 32'h0BAD_CAFE, rd, er, lat);
    do_op(1'b0, 1'b1, 1'b0, 32'h41, 32'h1234_5678, rd, er, lat);
    chk("T4_err", {31'b0, er}, 32'd1);
    chk("T4_rdata", rd, 32'd0);
    chk("T4_lat", lat, 32'd3);
    chk("T4_model_err", {31'b0, m_err}, 32'd1);
    do_op(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("T4_lw", rd, 32'h0BAD_CAFE);
    chk("T4_lw_err", {31'b0, er}, 32'd0);

    // T5: request held high through consecutive loads
    wait_idle(1'b0);
    t_we = 1'b0; t_byte = 1'b0; t_addr = 32'h10; req_a = 1'b1;
    @(posedge clk); #1;
    pulses = 0; idles = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (a_ready) pulses++;
      if (!a_busy) idles++;
    end
    req_a = 1'b0;
    chk("T5_pulses", pulses, 32'd2);
    chk("T5_idle_cycles", idles, 32'd2);
    chk("T5_rdata", a_rdata, 32'hDEAD_BEEF);

    // T6: reset lands while sb is in its merge cycle
    do_op(1'b0, 1'b1, 1'b0, 32'h50, 32'hCAFE_F00D, rd, er, lat);
    wait_idle(1'b0);
    t_we = 1'b1; t_byte = 1'b1; t_addr = 32'h51; t_wdata = 32'h55; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("T6_busy_pre", {31'b0, a_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("T6_ready", {31'b0, a_ready}, 32'd0);
    chk("T6_busy", {31'b0, a_busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(1'b0, 1'b0, 1'b0, 32'h50, 32'h0, rd, er, lat);
    chk("T6_mem", rd, 32'hCAFE_F00D);

    // Zero-wait-state instance
    do_op(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    chk("T6_w0_sw_lat", lat, 32'd1);
    do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("T6_w0_lw_lat", lat, 32'd1);
    chk("T6_w0_lw", rd, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b1, 1'b1, 32'h13, 32'h0000_0042, rd, er, lat);
    chk("T6_w0_sb_lat", lat, 32'd2);
    do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("T6_w0_merge", rd, 32'h42AD_BEEF);

    // Random traffic on instance A, including held requests, aliasing and resets
    for (int c = 0; c < 3000; c++) begin
      int idx, lane;
      @(posedge clk); #1;
      reset  = ($urandom_range(0, 199) == 0);
      req_a  = ($urandom_range(0, 2) == 0);
      t_we   = $urandom_range(0, 1) == 1;
      t_byte = $urandom_range(0, 1) == 1;
      idx    = $urandom_range(0, 23);
      if (t_byte) lane = $urandom_range(0, 3);
      else        lane = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      t_addr  = {20'($urandom_range(0, 1048575)), 10'(idx), 2'(lane)};
      t_wdata = $urandom;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    req_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
